// File: rtl/microsequencer.sv
// Next-state engine for the control unit: selects the next microstore state from the control-word sequencing fields.
// One-cycle latency (registered state); no backpressure, a memory wait holds the state until moc or a timeout fault.
module microsequencer #(
  parameter int                 STATE_W     = 7,
  parameter int                 TIMEOUT     = 16,
  parameter logic [STATE_W-1:0] FAULT_STATE = 7'd127
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         nsel,
  input  logic [1:0]         csel,
  input  logic               inv,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  input  logic               cond,
  output logic [STATE_W-1:0] currentState,
  output logic               waiting,
  output logic               mem_timeout
);

  localparam logic [2:0] NS_ENC    = 3'b000;
  localparam logic [2:0] NS_INC    = 3'b001;
  localparam logic [2:0] NS_CR     = 3'b010;
  localparam logic [2:0] NS_BR_INC = 3'b011;
  localparam logic [2:0] NS_BR_ENC = 3'b100;
  localparam logic [2:0] NS_WAIT   = 3'b101;
  localparam logic [2:0] NS_CALL   = 3'b110;

  localparam int                CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit                TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  WLAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [STATE_W-1:0] ret;
  logic [STATE_W-1:0] ret_nxt;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] inc;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   wcnt_nxt;
  logic               sel_cond;
  logic               t;
  logic               fault;

  always_comb begin
    case (csel)
      2'b00:   sel_cond = moc;
      2'b01:   sel_cond = cond;
      2'b10:   sel_cond = 1'b1;
      default: sel_cond = 1'b0;
    endcase
  end

  assign t       = sel_cond ^ inv;
  assign inc     = currentState + STATE_W'(1);
  assign waiting = (nsel == NS_WAIT) & ~t;

  // wcnt only survives an edge that keeps holding inside a wait; every other path clears it.
  always_comb begin
    nxt      = currentState;
    ret_nxt  = ret;
    wcnt_nxt = '0;
    fault    = 1'b0;
    case (nsel)
      NS_ENC:    nxt = enc_state;
      NS_INC:    nxt = inc;
      NS_CR:     nxt = cr;
      NS_BR_INC: nxt = t ? cr : inc;
      NS_BR_ENC: nxt = t ? cr : enc_state;
      NS_WAIT: begin
        if (t) begin
          nxt = inc;
        end else if (TO_EN && (wcnt == WLAST)) begin
          nxt   = FAULT_STATE;
          fault = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      NS_CALL: begin
        ret_nxt = inc;
        nxt     = cr;
      end
      default:   nxt = ret;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currentState <= '0;
      ret          <= '0;
      wcnt         <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      currentState <= nxt;
      ret          <= ret_nxt;
      wcnt         <= wcnt_nxt;
      if (fault) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer, built with TIMEOUT=4 so the fault path is reachable quickly.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] nsel;
  logic [1:0] csel;
  logic       inv;
  logic [6:0] cr;
  logic [6:0] enc_state;
  logic       moc;
  logic       cond;
  logic [6:0] currentState;
  logic       waiting;
  logic       mem_timeout;

  microsequencer #(.STATE_W(7), .TIMEOUT(4), .FAULT_STATE(7'd127)) dut (
    .clk(clk), .reset(reset), .nsel(nsel), .csel(csel), .inv(inv), .cr(cr),
    .enc_state(enc_state), .moc(moc), .cond(cond), .currentState(currentState),
    .waiting(waiting), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] n;
    logic [1:0] c;
    logic       i;
    logic [6:0] r;
    logic [6:0] e;
    logic       m;
    logic       cd;
    logic [6:0] x;
  } vec_t;

  int         compared   = 0;
  int         mismatched = 0;
  logic [6:0] exp_q[$];
  logic       exp_t_q[$];
  logic       exp_w_q[$];

  task automatic drive(input logic [2:0] n, input logic [1:0] c, input logic i,
                       input logic [6:0] r, input logic [6:0] e, input logic m, input logic cd);
    nsel = n; csel = c; inv = i; cr = r; enc_state = e; moc = m; cond = cd;
  endtask

  task automatic goto_state(input logic [6:0] s);
    drive(3'b010, 2'b11, 1'b0, s, 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [6:0] exp;
    reset = 1'b0;
    drive(3'b001, 2'b11, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (currentState !== 7'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", currentState); end
    compared++;
    if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    compared++;
    if (waiting !== 1'b0) begin mismatched++; $display("FAIL reset_waiting: got %b want 0", waiting); end
    reset = 1'b1;
    exp_q.push_back(7'd1);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    compared++;
    if (currentState !== exp) begin mismatched++; $display("FAIL first_edge: got %0d want %0d", currentState, exp); end
    goto_state(7'd45);
    compared++;
    if (currentState !== 7'd45) begin mismatched++; $display("FAIL goto45: got %0d want 45", currentState); end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (currentState !== 7'd0) begin mismatched++; $display("FAIL async_reset: got %0d want 0", currentState); end
    reset = 1'b1;
  endtask

  task automatic test_sequencing;
    vec_t       v[5];
    logic [6:0] exp;
    v[0] = '{3'b001, 2'b11, 1'b0, 7'd0,   7'd0,  1'b0, 1'b0, 7'd1};
    v[1] = '{3'b000, 2'b11, 1'b0, 7'd0,   7'd16, 1'b0, 1'b0, 7'd16};
    v[2] = '{3'b010, 2'b11, 1'b0, 7'd5,   7'd0,  1'b0, 1'b0, 7'd5};
    v[3] = '{3'b010, 2'b11, 1'b0, 7'd127, 7'd0,  1'b0, 1'b0, 7'd127};
    v[4] = '{3'b001, 2'b11, 1'b0, 7'd0,   7'd0,  1'b0, 1'b0, 7'd0};
    for (int k = 0; k < 5; k++) begin
      drive(v[k].n, v[k].c, v[k].i, v[k].r, v[k].e, v[k].m, v[k].cd);
      exp_q.push_back(v[k].x);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL seq[%0d]: got %0d want %0d", k, currentState, exp); end
    end
  endtask

  task automatic test_conditional;
    vec_t       v[7];
    logic [6:0] exp;
    v[0] = '{3'b010, 2'b11, 1'b0, 7'd20, 7'd0,  1'b0, 1'b0, 7'd20};
    v[1] = '{3'b011, 2'b01, 1'b0, 7'd30, 7'd0,  1'b0, 1'b1, 7'd30};
    v[2] = '{3'b010, 2'b11, 1'b0, 7'd20, 7'd0,  1'b0, 1'b0, 7'd20};
    v[3] = '{3'b011, 2'b01, 1'b1, 7'd30, 7'd0,  1'b0, 1'b1, 7'd21};
    v[4] = '{3'b100, 2'b11, 1'b0, 7'd99, 7'd40, 1'b0, 1'b0, 7'd40};
    v[5] = '{3'b100, 2'b10, 1'b0, 7'd77, 7'd40, 1'b0, 1'b0, 7'd77};
    v[6] = '{3'b011, 2'b00, 1'b1, 7'd5,  7'd0,  1'b1, 1'b0, 7'd78};
    for (int k = 0; k < 7; k++) begin
      drive(v[k].n, v[k].c, v[k].i, v[k].r, v[k].e, v[k].m, v[k].cd);
      exp_q.push_back(v[k].x);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL cond[%0d]: got %0d want %0d", k, currentState, exp); end
    end
  endtask

  task automatic test_mem_wait;
    logic [6:0] exp;
    logic       expw;
    goto_state(7'd2);
    for (int k = 0; k < 4; k++) begin
      drive(3'b101, 2'b00, 1'b0, 7'd0, 7'd0, (k == 3), 1'b0);
      exp_q.push_back((k == 3) ? 7'd3 : 7'd2);
      exp_w_q.push_back(k != 3);
      #1;
      expw = exp_w_q.pop_front();
      compared++;
      if (waiting !== expw) begin mismatched++; $display("FAIL wait_flag[%0d]: got %b want %b", k, waiting, expw); end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL wait_state[%0d]: got %0d want %0d", k, currentState, exp); end
    end
    goto_state(7'd2);
    drive(3'b101, 2'b00, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
    exp_q.push_back(7'd3);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    compared++;
    if (currentState !== exp) begin mismatched++; $display("FAIL wait_fast: got %0d want %0d", currentState, exp); end
  endtask

  task automatic test_timeout;
    logic [6:0] exp;
    logic       expt;
    goto_state(7'd7);
    for (int k = 0; k < 6; k++) begin
      if (k < 4)       drive(3'b101, 2'b00, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
      else if (k == 4) drive(3'b001, 2'b11, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
      else             drive(3'b010, 2'b11, 1'b0, 7'd9, 7'd0, 1'b0, 1'b0);
      exp_q.push_back((k < 3) ? 7'd7 : (k == 3) ? 7'd127 : (k == 4) ? 7'd0 : 7'd9);
      exp_t_q.push_back(k >= 3);
      @(posedge clk); #1;
      exp  = exp_q.pop_front();
      expt = exp_t_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL to_state[%0d]: got %0d want %0d", k, currentState, exp); end
      compared++;
      if (mem_timeout !== expt) begin mismatched++; $display("FAIL to_flag[%0d]: got %b want %b", k, mem_timeout, expt); end
    end
    reset = 1'b0;
    #1;
    compared++;
    if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL to_clear: got %b want 0", mem_timeout); end
    #1 reset = 1'b1;
    goto_state(7'd7);
    for (int k = 0; k < 4; k++) begin
      drive(3'b101, 2'b00, 1'b0, 7'd0, 7'd0, (k == 3), 1'b0);
      exp_q.push_back((k == 3) ? 7'd8 : 7'd7);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL to_edge[%0d]: got %0d want %0d", k, currentState, exp); end
    end
    compared++;
    if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL to_edge_flag: got %b want 0", mem_timeout); end
  endtask

  task automatic test_call_return;
    vec_t       v[11];
    logic [6:0] exp;
    reset = 1'b0;
    #2 reset = 1'b1;
    v[0]  = '{3'b010, 2'b11, 1'b0, 7'd33, 7'd0, 1'b0, 1'b0, 7'd33};
    v[1]  = '{3'b111, 2'b11, 1'b0, 7'd99, 7'd0, 1'b0, 1'b0, 7'd0};
    v[2]  = '{3'b010, 2'b11, 1'b0, 7'd10, 7'd0, 1'b0, 1'b0, 7'd10};
    v[3]  = '{3'b110, 2'b11, 1'b0, 7'd44, 7'd0, 1'b0, 1'b0, 7'd44};
    v[4]  = '{3'b111, 2'b11, 1'b0, 7'd99, 7'd0, 1'b0, 1'b0, 7'd11};
    v[5]  = '{3'b010, 2'b11, 1'b0, 7'd50, 7'd0, 1'b0, 1'b0, 7'd50};
    v[6]  = '{3'b110, 2'b11, 1'b0, 7'd60, 7'd0, 1'b0, 1'b0, 7'd60};
    v[7]  = '{3'b111, 2'b11, 1'b0, 7'd99, 7'd0, 1'b0, 1'b0, 7'd51};
    v[8]  = '{3'b010, 2'b11, 1'b0, 7'd70, 7'd0, 1'b0, 1'b0, 7'd70};
    v[9]  = '{3'b110, 2'b11, 1'b0, 7'd70, 7'd0, 1'b0, 1'b0, 7'd70};
    v[10] = '{3'b111, 2'b11, 1'b0, 7'd99, 7'd0, 1'b0, 1'b0, 7'd71};
    for (int k = 0; k < 11; k++) begin
      drive(v[k].n, v[k].c, v[k].i, v[k].r, v[k].e, v[k].m, v[k].cd);
      exp_q.push_back(v[k].x);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL call[%0d]: got %0d want %0d", k, currentState, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    reset = 1'b0;
    #2 reset = 1'b1;
    goto_state(7'd80);
    for (int k = 0; k < 20; k++) begin
      drive(3'b011, 2'b10, 1'b0, 7'd80, 7'd0, 1'b0, 1'b0);
      exp_q.push_back(7'd80);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL loop[%0d]: got %0d want %0d", k, currentState, exp); end
    end
    for (int k = 0; k < 8; k++) begin
      drive(3'b101, 2'b00, 1'b0, 7'd0, 7'd0, (k % 4 == 3), 1'b0);
      exp_q.push_back((k < 3) ? 7'd80 : (k < 7) ? 7'd81 : 7'd82);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      compared++;
      if (currentState !== exp) begin mismatched++; $display("FAIL rewait[%0d]: got %0d want %0d", k, currentState, exp); end
    end
    compared++;
    if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL rewait_flag: got %b want 0", mem_timeout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequencing();
    test_conditional();
    test_mem_wait();
    test_timeout();
    test_call_return();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
